// File: rtl/multi_input_logic_reducer_pkg.sv
// Shared op-code encodings and identity helper for the logic reducer.
package logic_reducer_pkg;

    localparam logic [1:0] MODE_OR  = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;
    localparam int         MODE_INV = 2;

    // Seed value for an empty reduction: all-1 for AND, all-0 for OR/XOR.
    function automatic logic op_identity(input logic [1:0] op);
        return (op == MODE_AND);
    endfunction

endpackage

// File: rtl/multi_input_logic_reducer_reduce_stage.sv
// Purpose: two-operand bitwise OR/AND/XOR; code 3 falls through to OR.
// Latency: combinational.
// Backpressure: none, pure function of inputs.
module reduce_stage
    import logic_reducer_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a | b;
        case (op)
            MODE_AND: y = a & b;
            MODE_XOR: y = a ^ b;
            default:  y = a | b;
        endcase
    end

endmodule

// File: rtl/multi_input_logic_reducer.sv
// Purpose: pipelined N-input bitwise reducer with partial result, sticky OR accumulator, saturating beat count.
// Latency: accept at edge T, output handshake possible at edge T+2; one beat per cycle.
// Backpressure: in_ready = stage 1 free or advancing; bubbles collapse, stalled outputs hold.
module multi_input_logic_reducer
    import logic_reducer_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [2:0]            mode,
    input  logic                  acc_en,
    input  logic                  acc_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_partial,
    output logic [WIDTH-1:0]      out_result,
    output logic [WIDTH-1:0]      out_acc,
    output logic [CNT_W-1:0]      out_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_r;
    logic [2:0]       s1_mode;
    logic             s1_acc_en;
    logic             s2_valid;
    logic             s2_acc_en;
    logic             adv1;
    logic             adv2;
    logic             out_hs;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] comb_d;
    logic [WIDTH-1:0] acc_beat;
    logic [WIDTH-1:0] r_chain [2:N_IN];

    assign in_op    = mode[1:0];
    assign adv2     = ~s2_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;
    assign out_valid = s2_valid;
    assign out_hs   = s2_valid & out_ready;

    reduce_stage #(.WIDTH(WIDTH)) u_partial (
        .op (in_op),
        .a  (in_data[0 +: WIDTH]),
        .b  (in_data[WIDTH +: WIDTH]),
        .y  (p_d)
    );

    // Remaining operands fold left starting from the op identity, so N_IN==2 yields identity.
    assign r_chain[2] = {WIDTH{op_identity(in_op)}};

    for (genvar k = 2; k < N_IN; k++) begin : g_rest
        reduce_stage #(.WIDTH(WIDTH)) u_rest (
            .op (in_op),
            .a  (r_chain[k]),
            .b  (in_data[k*WIDTH +: WIDTH]),
            .y  (r_chain[k+1])
        );
    end

    reduce_stage #(.WIDTH(WIDTH)) u_final (
        .op (s1_mode[1:0]),
        .a  (s1_p),
        .b  (s1_r),
        .y  (comb_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_p      <= '0;
            s1_r      <= '0;
            s1_mode   <= '0;
            s1_acc_en <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p      <= p_d;
                s1_r      <= r_chain[N_IN];
                s1_mode   <= mode;
                s1_acc_en <= acc_en;
            end
        end
    end

    // Inversion lives only at the output stage so p/r stay in the raw op domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            s2_acc_en   <= 1'b0;
            out_partial <= '0;
            out_result  <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_acc_en   <= s1_acc_en;
                out_partial <= s1_p   ^ {WIDTH{s1_mode[MODE_INV]}};
                out_result  <= comb_d ^ {WIDTH{s1_mode[MODE_INV]}};
            end
        end
    end

    assign acc_beat = s2_acc_en ? out_result : '0;

    // A clear coinciding with a handshake wipes history first, then counts that beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_acc   <= '0;
            out_count <= '0;
        end else if (acc_clr) begin
            out_acc   <= out_hs ? acc_beat : '0;
            out_count <= out_hs ? CNT_W'(1) : '0;
        end else if (out_hs) begin
            out_acc <= out_acc | acc_beat;
            if (out_count != '1)
                out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multi_input_logic_reducer.sv
// Directed bench: three reducer configurations driven from one linear stimulus sequence.
module tb_multi_input_logic_reducer;

    logic clk = 1'b0;
    logic rst;

    // Instance A: defaults N_IN=3 WIDTH=1 CNT_W=8
    logic       a_in_valid, a_in_ready, a_acc_en, a_acc_clr, a_out_valid, a_out_ready;
    logic [2:0] a_in_data, a_mode;
    logic       a_out_partial, a_out_result, a_out_acc;
    logic [7:0] a_out_count;

    // Instance B: N_IN=4 WIDTH=4 CNT_W=8
    logic        b_in_valid, b_in_ready, b_acc_en, b_acc_clr, b_out_valid, b_out_ready;
    logic [15:0] b_in_data;
    logic [2:0]  b_mode;
    logic [3:0]  b_out_partial, b_out_result, b_out_acc;
    logic [7:0]  b_out_count;

    // Instance C: N_IN=2 WIDTH=4 CNT_W=2
    logic       c_in_valid, c_in_ready, c_acc_en, c_acc_clr, c_out_valid, c_out_ready;
    logic [7:0] c_in_data;
    logic [2:0] c_mode;
    logic [3:0] c_out_partial, c_out_result, c_out_acc;
    logic [1:0] c_out_count;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    logic [2:0] t3_mode [7];
    logic [3:0] t3_res  [7];
    logic [3:0] t3_par  [7];
    logic [2:0] t6_mode [5];
    logic [3:0] t6_res  [5];

    always #5 clk = ~clk;

    multi_input_logic_reducer u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .mode(a_mode), .acc_en(a_acc_en), .acc_clr(a_acc_clr), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_partial(a_out_partial), .out_result(a_out_result),
        .out_acc(a_out_acc), .out_count(a_out_count)
    );

    multi_input_logic_reducer #(.N_IN(4), .WIDTH(4), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .mode(b_mode), .acc_en(b_acc_en), .acc_clr(b_acc_clr), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_partial(b_out_partial), .out_result(b_out_result),
        .out_acc(b_out_acc), .out_count(b_out_count)
    );

    multi_input_logic_reducer #(.N_IN(2), .WIDTH(4), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .mode(c_mode), .acc_en(c_acc_en), .acc_clr(c_acc_clr), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_partial(c_out_partial), .out_result(c_out_result),
        .out_acc(c_out_acc), .out_count(c_out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] v;
        int sent, got, exp_cnt;
        logic sent_now;

        t3_mode[0] = 3'd1; t3_res[0] = 4'h0; t3_par[0] = 4'h8;
        t3_mode[1] = 3'd2; t3_res[1] = 4'h8; t3_par[1] = 4'h6;
        t3_mode[2] = 3'd6; t3_res[2] = 4'h7; t3_par[2] = 4'h9;
        t3_mode[3] = 3'd3; t3_res[3] = 4'hF; t3_par[3] = 4'hE;
        t3_mode[4] = 3'd0; t3_res[4] = 4'hF; t3_par[4] = 4'hE;
        t3_mode[5] = 3'd4; t3_res[5] = 4'h0; t3_par[5] = 4'h1;
        t3_mode[6] = 3'd5; t3_res[6] = 4'hF; t3_par[6] = 4'h7;
        t6_mode[0] = 3'd2; t6_res[0] = 4'h6;
        t6_mode[1] = 3'd1; t6_res[1] = 4'h8;
        t6_mode[2] = 3'd5; t6_res[2] = 4'h7;
        t6_mode[3] = 3'd0; t6_res[3] = 4'hE;
        t6_mode[4] = 3'd3; t6_res[4] = 4'hE;

        rst = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_mode = '0; a_acc_en = 0; a_acc_clr = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_mode = '0; b_acc_en = 0; b_acc_clr = 0; b_out_ready = 0;
        c_in_valid = 0; c_in_data = '0; c_mode = '0; c_acc_en = 0; c_acc_clr = 0; c_out_ready = 0;
        #12;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_result", a_out_result, 0);
        chk("rst_out_count", a_out_count, 0);
        rst = 1'b0;
        step();

        // Reset mid-stream with both stages full
        a_in_valid = 1; a_in_data = 3'b111; a_acc_en = 1; a_out_ready = 0;
        step();
        step();
        chk("t1_full_in_ready", a_in_ready, 0);
        chk("t1_full_out_valid", a_out_valid, 1);
        chk("t1_full_result", a_out_result, 1);
        rst = 1'b1;
        #1;
        chk("t1_rst_out_valid", a_out_valid, 0);
        chk("t1_rst_out_acc", a_out_acc, 0);
        chk("t1_rst_out_count", a_out_count, 0);
        chk("t1_rst_in_ready", a_in_ready, 1);
        chk("t1_rst_result", a_out_result, 0);
        a_in_valid = 0; a_acc_en = 0;
        #1;
        rst = 1'b0;
        step();
        chk("t1_post_out_valid", a_out_valid, 0);
        step();
        chk("t1_post2_out_valid", a_out_valid, 0);

        // Eight OR combos streamed back to back
        a_mode = 3'd0; a_out_ready = 1;
        for (int c = 0; c < 10; c++) begin
            a_in_valid = (c < 8);
            a_in_data = 3'(c);
            step();
            chk("t2_in_ready", a_in_ready, 1);
            chk("t2_out_valid", a_out_valid, (c >= 1 && c <= 8));
            if (c >= 1 && c <= 8) begin
                v = 3'(c - 1);
                chk("t2_partial", a_out_partial, v[0] | v[1]);
                chk("t2_result", a_out_result, v[0] | v[1] | v[2]);
            end
        end
        chk("t2_count", a_out_count, 8);
        chk("t2_acc", a_out_acc, 0);

        // Mode table on 0xA,0xC,0xF,0x1
        b_out_ready = 1; b_in_data = 16'h1FCA;
        for (int c = 0; c < 9; c++) begin
            b_in_valid = (c < 7);
            if (c < 7) b_mode = t3_mode[c];
            step();
            chk("t3_out_valid", b_out_valid, (c >= 1 && c <= 7));
            if (c >= 1 && c <= 7) begin
                chk("t3_result", b_out_result, t3_res[c-1]);
                chk("t3_partial", b_out_partial, t3_par[c-1]);
            end
        end
        chk("t3_count", b_out_count, 7);

        // Backpressure: sink stalled for five cycles under continuous input
        b_mode = 3'd0; sent = 0; got = 0;
        for (int c = 0; c < 16; c++) begin
            b_out_ready = (c >= 5);
            b_in_valid = (sent < 6);
            b_in_data = {12'h0, 4'(sent + 1)};
            #1;
            if (c >= 2 && c <= 4) begin
                chk("t4_in_ready_low", b_in_ready, 0);
                chk("t4_hold_result", b_out_result, 1);
                chk("t4_hold_partial", b_out_partial, 1);
                chk("t4_hold_valid", b_out_valid, 1);
            end
            if (b_out_valid && b_out_ready) begin
                chk("t4_order", b_out_result, got + 1);
                got++;
            end
            sent_now = b_in_valid & b_in_ready;
            if (sent_now) sent++;
            step();
        end
        chk("t4_delivered", got, 6);
        chk("t4_accepted", sent, 6);

        // Accumulator
        b_in_valid = 0; b_acc_clr = 1;
        step();
        b_acc_clr = 0;
        chk("t5_clr_acc", b_out_acc, 0);
        chk("t5_clr_count", b_out_count, 0);
        b_in_valid = 1; b_in_data = 16'h0001; b_acc_en = 1;
        step();
        b_in_data = 16'h0004; b_acc_en = 0;
        step();
        b_in_data = 16'h0008; b_acc_en = 1;
        step();
        chk("t5_acc_first", b_out_acc, 4'h1);
        b_in_valid = 0; b_acc_en = 0;
        step();
        chk("t5_acc_untagged", b_out_acc, 4'h1);
        step();
        chk("t5_acc", b_out_acc, 4'h9);
        chk("t5_count", b_out_count, 3);
        b_in_valid = 1; b_in_data = 16'h0002; b_acc_en = 1;
        step();
        b_in_valid = 0; b_acc_en = 0;
        step();
        b_acc_clr = 1;
        chk("t5_beat4_valid", b_out_valid, 1);
        step();
        b_acc_clr = 0;
        chk("t5_clr_hs_acc", b_out_acc, 4'h2);
        chk("t5_clr_hs_count", b_out_count, 1);

        // Two-operand instance, count saturates at 3
        c_out_ready = 1; c_in_data = 8'hCA;
        for (int c = 0; c < 7; c++) begin
            c_in_valid = (c < 5);
            if (c < 5) c_mode = t6_mode[c];
            step();
            exp_cnt = (c < 2) ? 0 : ((c - 1 > 3) ? 3 : c - 1);
            chk("t6_count", c_out_count, exp_cnt);
            if (c >= 1 && c <= 5) begin
                chk("t6_result", c_out_result, t6_res[c-1]);
                chk("t6_partial", c_out_partial, t6_res[c-1]);
            end
        end
        chk("t6_count_final", c_out_count, 3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
